// File: rtl/config_pkg.sv
// Core configuration slice: physical address width and the static
// cached / executable / non-idempotent address rules used as fallback
// attributes when no runtime PMA region matches.
package config_pkg;

    localparam int unsigned NrMaxRules = 4;

    typedef struct packed {
        int unsigned                      PLEN;
        int unsigned                      NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0]      NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0]      NonIdempotentLength;
        int unsigned                      NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0]      ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0]      ExecuteRegionLength;
        int unsigned                      NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0]      CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0]      CachedRegionLength;
    } cva6_cfg_t;

    // Empty configuration: 32-bit physical space, no static rules.
    function automatic cva6_cfg_t build_empty_cfg();
        cva6_cfg_t c;
        c      = '0;
        c.PLEN = 32;
        return c;
    endfunction

    localparam cva6_cfg_t cva6_cfg_empty = build_empty_cfg();

endpackage

// File: rtl/pma_pkg.sv
// Shared PMA region table definitions: attribute layout, programming
// field encoding, region count limit and the no-wrap range check.
package pma_pkg;

    localparam int unsigned MaxRegions = 16;
    localparam int unsigned AttrW      = 5;

    // Bit positions inside the attribute word (LSB first).
    localparam int unsigned AttrValid   = 0;
    localparam int unsigned AttrCached  = 1;
    localparam int unsigned AttrExec    = 2;
    localparam int unsigned AttrNonidem = 3;

    typedef struct packed {
        logic lock;
        logic nonidem;
        logic exec;
        logic cached;
        logic valid;
    } pma_attr_t;

    typedef enum logic [1:0] {
        FIELD_BASE = 2'd0,
        FIELD_LEN  = 2'd1,
        FIELD_ATTR = 2'd2,
        FIELD_RSVD = 2'd3
    } pma_field_e;

    // base <= addr < base + len, with the limit held one bit wider so a
    // region ending at the top of the address space never wraps to 0.
    function automatic logic range_hit(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] len);
        logic [64:0] limit;
        limit = {1'b0, base} + {1'b0, len};
        return (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/pma_region_match.sv
// One lookup channel: priority match of a single address against the
// runtime region table, falling back to the static core rules on a miss.
module pma_region_match #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NrRegions = 8
) (
    input  logic [CVA6Cfg.PLEN-1:0]                addr_i,
    input  logic [NrRegions-1:0][CVA6Cfg.PLEN-1:0] base_i,
    input  logic [NrRegions-1:0][CVA6Cfg.PLEN-1:0] len_i,
    input  logic [NrRegions-1:0][3:0]              attr_i,
    output logic                                   hit_o,
    output logic                                   cached_o,
    output logic                                   exec_o,
    output logic                                   nonidem_o
);
    import pma_pkg::*;

    localparam int unsigned PLEN = CVA6Cfg.PLEN;

    function automatic logic [63:0] ext(input logic [PLEN-1:0] v);
        logic [63:0] r;
        r          = '0;
        r[PLEN-1:0] = v;
        return r;
    endfunction

    logic [63:0] addr_ext;
    logic        static_cached;
    logic        static_exec;
    logic        static_nonidem;

    // Static fallback attributes from the core configuration rules.
    always_comb begin
        addr_ext       = ext(addr_i);
        static_cached  = 1'b0;
        static_exec    = 1'b0;
        static_nonidem = 1'b0;
        for (int unsigned r = 0; r < config_pkg::NrMaxRules; r++) begin
            if (r < CVA6Cfg.NrCachedRegionRules &&
                range_hit(addr_ext, CVA6Cfg.CachedRegionAddrBase[r], CVA6Cfg.CachedRegionLength[r]))
                static_cached = 1'b1;
            if (r < CVA6Cfg.NrExecuteRegionRules &&
                range_hit(addr_ext, CVA6Cfg.ExecuteRegionAddrBase[r], CVA6Cfg.ExecuteRegionLength[r]))
                static_exec = 1'b1;
            if (r < CVA6Cfg.NrNonIdempotentRules &&
                range_hit(addr_ext, CVA6Cfg.NonIdempotentAddrBase[r], CVA6Cfg.NonIdempotentLength[r]))
                static_nonidem = 1'b1;
        end
    end

    // Scan from the highest index down so the lowest matching region wins.
    always_comb begin
        hit_o     = 1'b0;
        cached_o  = static_cached;
        exec_o    = static_exec;
        nonidem_o = static_nonidem;
        for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
            if (attr_i[i][AttrValid] && range_hit(addr_ext, ext(base_i[i]), ext(len_i[i]))) begin
                hit_o     = 1'b1;
                cached_o  = attr_i[i][AttrCached];
                exec_o    = attr_i[i][AttrExec];
                nonidem_o = attr_i[i][AttrNonidem];
            end
        end
    end

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table with a one-cycle programming
// response port and NrLookupPorts independent attribute lookup channels.
module pma_region_table #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg       = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NrRegions     = 8,
    parameter int unsigned           NrLookupPorts = 2,
    parameter int unsigned           LookupLatency = 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       cfg_req_i,
    input  logic                                       cfg_we_i,
    input  logic [((NrRegions > 1) ? $clog2(NrRegions) : 1)-1:0] cfg_idx_i,
    input  logic [1:0]                                 cfg_field_i,
    input  logic [CVA6Cfg.PLEN-1:0]                    cfg_wdata_i,
    output logic                                       cfg_rvalid_o,
    output logic [CVA6Cfg.PLEN-1:0]                    cfg_rdata_o,
    output logic                                       cfg_err_o,
    input  logic [NrLookupPorts-1:0]                   lkp_valid_i,
    input  logic [NrLookupPorts-1:0][CVA6Cfg.PLEN-1:0] lkp_addr_i,
    output logic [NrLookupPorts-1:0]                   lkp_valid_o,
    output logic [NrLookupPorts-1:0]                   lkp_hit_o,
    output logic [NrLookupPorts-1:0]                   lkp_cached_o,
    output logic [NrLookupPorts-1:0]                   lkp_exec_o,
    output logic [NrLookupPorts-1:0]                   lkp_nonidem_o
);
    import pma_pkg::*;

    localparam int unsigned PLEN = CVA6Cfg.PLEN;
    localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1;

    logic [NrRegions-1:0][PLEN-1:0]  base_q, base_d;
    logic [NrRegions-1:0][PLEN-1:0]  len_q, len_d;
    logic [NrRegions-1:0][AttrW-1:0] attr_q, attr_d;
    logic                            cfg_rvalid_q, cfg_rvalid_d;
    logic                            cfg_err_q, cfg_err_d;
    logic [PLEN-1:0]                 cfg_rdata_q, cfg_rdata_d;

    logic                            idx_oob;
    logic [IdxW-1:0]                 idx;
    pma_attr_t                       cur_attr;
    pma_field_e                      field;

    // Decode a programming request into the next table state and response.
    // Errors (bad index, reserved field, write to a locked region) leave
    // the table untouched; the lock check uses the registered attr, so a
    // write that sets lock only restricts requests from the next cycle on.
    always_comb begin
        base_d       = base_q;
        len_d        = len_q;
        attr_d       = attr_q;
        cfg_rvalid_d = cfg_req_i;
        cfg_err_d    = 1'b0;
        cfg_rdata_d  = '0;
        idx_oob      = (32'(cfg_idx_i) >= NrRegions);
        idx          = idx_oob ? '0 : cfg_idx_i;
        field        = pma_field_e'(cfg_field_i);
        cur_attr     = pma_attr_t'(attr_q[idx]);
        if (cfg_req_i) begin
            cfg_err_d = idx_oob || (field == FIELD_RSVD) || (cfg_we_i && cur_attr.lock);
            if (!cfg_err_d) begin
                if (cfg_we_i) begin
                    case (field)
                        FIELD_BASE: base_d[idx] = cfg_wdata_i;
                        FIELD_LEN:  len_d[idx]  = cfg_wdata_i;
                        FIELD_ATTR: attr_d[idx] = cfg_wdata_i[AttrW-1:0];
                        default:    ;
                    endcase
                end else begin
                    case (field)
                        FIELD_BASE: cfg_rdata_d = base_q[idx];
                        FIELD_LEN:  cfg_rdata_d = len_q[idx];
                        FIELD_ATTR: cfg_rdata_d = PLEN'(attr_q[idx]);
                        default:    ;
                    endcase
                end
            end
        end
    end

    // Table and programming response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q       <= '0;
            len_q        <= '0;
            attr_q       <= '0;
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            base_q       <= base_d;
            len_q        <= len_d;
            attr_q       <= attr_d;
            cfg_rvalid_q <= cfg_rvalid_d;
            cfg_err_q    <= cfg_err_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_err_o    = cfg_err_q;
    assign cfg_rdata_o  = cfg_rdata_q;

    logic [NrRegions-1:0][3:0]   match_attr;
    logic [NrLookupPorts-1:0]    hit_c, cached_c, exec_c, nonidem_c;

    // Matchers only need the lookup-relevant attribute bits.
    always_comb begin
        for (int r = 0; r < int'(NrRegions); r++) begin
            match_attr[r] = attr_q[r][3:0];
        end
    end

    for (genvar g = 0; g < int'(NrLookupPorts); g++) begin : gen_match
        pma_region_match #(
            .CVA6Cfg   (CVA6Cfg),
            .NrRegions (NrRegions)
        ) i_match (
            .addr_i    (lkp_addr_i[g]),
            .base_i    (base_q),
            .len_i     (len_q),
            .attr_i    (match_attr),
            .hit_o     (hit_c[g]),
            .cached_o  (cached_c[g]),
            .exec_o    (exec_c[g]),
            .nonidem_o (nonidem_c[g])
        );
    end

    if (LookupLatency == 0) begin : gen_lkp_comb
        assign lkp_valid_o   = lkp_valid_i;
        assign lkp_hit_o     = hit_c;
        assign lkp_cached_o  = cached_c;
        assign lkp_exec_o    = exec_c;
        assign lkp_nonidem_o = nonidem_c;
    end else begin : gen_lkp_reg
        logic [NrLookupPorts-1:0] valid_q, hit_q, cached_q, exec_q, nonidem_q;

        // Register lookup results so they appear one cycle after the request.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q   <= '0;
                hit_q     <= '0;
                cached_q  <= '0;
                exec_q    <= '0;
                nonidem_q <= '0;
            end else begin
                valid_q   <= lkp_valid_i;
                hit_q     <= hit_c;
                cached_q  <= cached_c;
                exec_q    <= exec_c;
                nonidem_q <= nonidem_c;
            end
        end

        assign lkp_valid_o   = valid_q;
        assign lkp_hit_o     = hit_q;
        assign lkp_cached_o  = cached_q;
        assign lkp_exec_o    = exec_q;
        assign lkp_nonidem_o = nonidem_q;
    end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table: 6 regions, 4 lookup ports,
// registered lookups, and a core config with static attribute rules.
module tb_pma_region_table;

    localparam int unsigned PLEN = 32;
    localparam int unsigned NR   = 6;
    localparam int unsigned NP   = 4;

    localparam logic [1:0] F_BASE = 2'd0;
    localparam logic [1:0] F_LEN  = 2'd1;
    localparam logic [1:0] F_ATTR = 2'd2;
    localparam logic [1:0] F_RSVD = 2'd3;

    // Static rules: cached+exec in [0x8000_0000, 0xC000_0000),
    // non-idempotent in [0, 0x8000_0000).
    function automatic config_pkg::cva6_cfg_t mk_cfg();
        config_pkg::cva6_cfg_t c;
        c                          = '0;
        c.PLEN                     = PLEN;
        c.NrCachedRegionRules      = 1;
        c.CachedRegionAddrBase[0]  = 64'h8000_0000;
        c.CachedRegionLength[0]    = 64'h4000_0000;
        c.NrExecuteRegionRules     = 1;
        c.ExecuteRegionAddrBase[0] = 64'h8000_0000;
        c.ExecuteRegionLength[0]   = 64'h4000_0000;
        c.NrNonIdempotentRules     = 1;
        c.NonIdempotentAddrBase[0] = 64'h0;
        c.NonIdempotentLength[0]   = 64'h8000_0000;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t TbCfg = mk_cfg();

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     cfg_req_i;
    logic                     cfg_we_i;
    logic [2:0]               cfg_idx_i;
    logic [1:0]               cfg_field_i;
    logic [PLEN-1:0]          cfg_wdata_i;
    logic                     cfg_rvalid_o;
    logic [PLEN-1:0]          cfg_rdata_o;
    logic                     cfg_err_o;
    logic [NP-1:0]            lkp_valid_i;
    logic [NP-1:0][PLEN-1:0]  lkp_addr_i;
    logic [NP-1:0]            lkp_valid_o;
    logic [NP-1:0]            lkp_hit_o;
    logic [NP-1:0]            lkp_cached_o;
    logic [NP-1:0]            lkp_exec_o;
    logic [NP-1:0]            lkp_nonidem_o;

    int checks   = 0;
    int failures = 0;

    pma_region_table #(
        .CVA6Cfg       (TbCfg),
        .NrRegions     (NR),
        .NrLookupPorts (NP),
        .LookupLatency (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_req_i     (cfg_req_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_idx_i     (cfg_idx_i),
        .cfg_field_i   (cfg_field_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_rvalid_o  (cfg_rvalid_o),
        .cfg_rdata_o   (cfg_rdata_o),
        .cfg_err_o     (cfg_err_o),
        .lkp_valid_i   (lkp_valid_i),
        .lkp_addr_i    (lkp_addr_i),
        .lkp_valid_o   (lkp_valid_o),
        .lkp_hit_o     (lkp_hit_o),
        .lkp_cached_o  (lkp_cached_o),
        .lkp_exec_o    (lkp_exec_o),
        .lkp_nonidem_o (lkp_nonidem_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One programming request, then check the response of the next cycle.
    task automatic cfg(input string tag, input logic we, input int idx, input logic [1:0] f,
                       input logic [PLEN-1:0] wd, input logic exp_err, input logic [PLEN-1:0] exp_rd);
        cfg_req_i   = 1'b1;
        cfg_we_i    = we;
        cfg_idx_i   = idx[2:0];
        cfg_field_i = f;
        cfg_wdata_i = wd;
        tick();
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        chk({tag, ".rvalid"}, 64'(cfg_rvalid_o), 64'(1'b1));
        chk({tag, ".err"},    64'(cfg_err_o),    64'(exp_err));
        chk({tag, ".rdata"},  64'(cfg_rdata_o),  64'(exp_rd));
    endtask

    // Result of channel ch as {hit, cached, exec, nonidem}.
    task automatic chk_lk(input string tag, input int ch, input logic [3:0] exp);
        chk(tag, 64'({lkp_hit_o[ch], lkp_cached_o[ch], lkp_exec_o[ch], lkp_nonidem_o[ch]}), 64'(exp));
    endtask

    initial begin
        rst_ni      = 1'b0;
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_idx_i   = '0;
        cfg_field_i = F_BASE;
        cfg_wdata_i = '0;
        lkp_valid_i = '1;
        lkp_addr_i  = '0;

        // Reset holds every response and lookup output at zero.
        repeat (3) tick();
        chk("rst.rvalid",  64'(cfg_rvalid_o), 64'd0);
        chk("rst.err",     64'(cfg_err_o),    64'd0);
        chk("rst.rdata",   64'(cfg_rdata_o),  64'd0);
        chk("rst.lvalid",  64'(lkp_valid_o),  64'd0);
        chk("rst.hit",     64'(lkp_hit_o),    64'd0);
        chk("rst.nonidem", 64'(lkp_nonidem_o), 64'd0);
        cfg_req_i   = 1'b0;
        lkp_valid_i = '0;
        rst_ni      = 1'b1;
        tick();
        chk("idle.rvalid", 64'(cfg_rvalid_o), 64'd0);

        // Program region 0 and probe its last byte and the byte past it.
        cfg("p0.base", 1'b1, 0, F_BASE, 32'h8000_0000, 1'b0, '0);
        cfg("p0.len",  1'b1, 0, F_LEN,  32'h0000_1000, 1'b0, '0);
        cfg("p0.attr", 1'b1, 0, F_ATTR, 32'h0000_0003, 1'b0, '0);
        cfg("p0.rbase", 1'b0, 0, F_BASE, '0, 1'b0, 32'h8000_0000);
        cfg("p0.rlen",  1'b0, 0, F_LEN,  '0, 1'b0, 32'h0000_1000);
        cfg("p0.rattr", 1'b0, 0, F_ATTR, '0, 1'b0, 32'h0000_0003);
        tick();
        chk("pulse.rvalid", 64'(cfg_rvalid_o), 64'd0);
        lkp_valid_i   = 4'b0011;
        lkp_addr_i[0] = 32'h8000_0FFF;
        lkp_addr_i[1] = 32'h8000_1000;
        tick();
        chk_lk("p0.in",   0, 4'b1100);
        chk_lk("p0.past", 1, 4'b0110);
        lkp_valid_i = '0;

        // Overlapping regions: region 1 (non-idempotent) beats region 3 (cached).
        cfg("ov.b1", 1'b1, 1, F_BASE, 32'h0000_0000, 1'b0, '0);
        cfg("ov.l1", 1'b1, 1, F_LEN,  32'h0000_2000, 1'b0, '0);
        cfg("ov.a1", 1'b1, 1, F_ATTR, 32'h0000_0009, 1'b0, '0);
        cfg("ov.b3", 1'b1, 3, F_BASE, 32'h0000_1000, 1'b0, '0);
        cfg("ov.l3", 1'b1, 3, F_LEN,  32'h0000_2000, 1'b0, '0);
        cfg("ov.a3", 1'b1, 3, F_ATTR, 32'h0000_0003, 1'b0, '0);
        lkp_valid_i   = 4'b1111;
        lkp_addr_i[0] = 32'h0000_1800;
        lkp_addr_i[1] = 32'h0000_2800;
        lkp_addr_i[2] = 32'h0000_3000;
        lkp_addr_i[3] = 32'h0000_0FFF;
        tick();
        chk_lk("ov.both", 0, 4'b1001);
        chk_lk("ov.r3",   1, 4'b1100);
        chk_lk("ov.miss", 2, 4'b0001);
        chk_lk("ov.r1",   3, 4'b1001);
        lkp_valid_i = '0;

        // Lock region 2, then every write to it errors and changes nothing.
        cfg("lk.attr",  1'b1, 2, F_ATTR, 32'h0000_0011, 1'b0, '0);
        cfg("lk.wbase", 1'b1, 2, F_BASE, 32'h0000_5000, 1'b1, '0);
        cfg("lk.rbase", 1'b0, 2, F_BASE, '0, 1'b0, '0);
        cfg("lk.wattr", 1'b1, 2, F_ATTR, 32'h0000_0000, 1'b1, '0);
        cfg("lk.rattr", 1'b0, 2, F_ATTR, '0, 1'b0, 32'h0000_0011);
        cfg("lk.rsvd",  1'b0, 0, F_RSVD, '0, 1'b1, '0);

        // Reset during a pending response clears it immediately.
        cfg("ab.req", 1'b0, 2, F_ATTR, '0, 1'b0, 32'h0000_0011);
        rst_ni = 1'b0;
        #1;
        chk("ab.rvalid", 64'(cfg_rvalid_o), 64'd0);
        chk("ab.rdata",  64'(cfg_rdata_o),  64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("ab.after", 64'(cfg_rvalid_o), 64'd0);

        // After reset the lock is gone and the table is empty.
        cfg("ul.wbase", 1'b1, 2, F_BASE, 32'h0000_5000, 1'b0, '0);
        cfg("ul.rbase", 1'b0, 2, F_BASE, '0, 1'b0, 32'h0000_5000);
        cfg("ul.rattr", 1'b0, 2, F_ATTR, '0, 1'b0, '0);
        lkp_valid_i   = 4'b0001;
        lkp_addr_i[0] = 32'h8000_0FFF;
        tick();
        chk_lk("ul.p0gone", 0, 4'b0110);

        // Enabling write and lookup in the same cycle: lookup sees old table.
        cfg("sim.base", 1'b1, 0, F_BASE, 32'h9000_0000, 1'b0, '0);
        cfg("sim.len",  1'b1, 0, F_LEN,  32'h0000_0100, 1'b0, '0);
        lkp_addr_i[0] = 32'h9000_0010;
        cfg("sim.attr", 1'b1, 0, F_ATTR, 32'h0000_0001, 1'b0, '0);
        chk_lk("sim.same", 0, 4'b0110);
        tick();
        chk_lk("sim.next", 0, 4'b1000);
        // Shrinking a valid region takes effect from the following lookup.
        cfg("sh.len", 1'b1, 0, F_LEN, 32'h0000_0010, 1'b0, '0);
        chk_lk("sh.same", 0, 4'b1000);
        tick();
        chk_lk("sh.next", 0, 4'b0110);

        // Region touching the top of the address space must not wrap.
        cfg("bd.base", 1'b1, 4, F_BASE, 32'hFFFF_FFF0, 1'b0, '0);
        cfg("bd.len",  1'b1, 4, F_LEN,  32'h0000_0020, 1'b0, '0);
        cfg("bd.attr", 1'b1, 4, F_ATTR, 32'h0000_0005, 1'b0, '0);
        lkp_valid_i   = 4'b1111;
        lkp_addr_i[0] = 32'hFFFF_FFFF;
        lkp_addr_i[1] = 32'h0000_0000;
        lkp_addr_i[2] = 32'hFFFF_FFEF;
        lkp_addr_i[3] = 32'hFFFF_FFF0;
        tick();
        chk_lk("bd.top",   0, 4'b1010);
        chk_lk("bd.zero",  1, 4'b0001);
        chk_lk("bd.below", 2, 4'b0000);
        chk_lk("bd.first", 3, 4'b1010);
        chk("bd.lvalid", 64'(lkp_valid_o), 64'hF);
        cfg("bd.idx6", 1'b1, 6, F_BASE, 32'h1234_0000, 1'b1, '0);
        cfg("bd.idx7", 1'b0, 7, F_BASE, '0, 1'b1, '0);

        // Four independent channels; valid_o trails valid_i by one cycle.
        lkp_valid_i   = 4'b0101;
        lkp_addr_i[0] = 32'h9000_0005;
        lkp_addr_i[1] = 32'h0000_5000;
        lkp_addr_i[2] = 32'hFFFF_FFF8;
        lkp_addr_i[3] = 32'hA000_0000;
        #1;
        chk("mp.before", 64'(lkp_valid_o), 64'hF);
        tick();
        chk("mp.lvalid", 64'(lkp_valid_o), 64'h5);
        chk_lk("mp.ch0", 0, 4'b1000);
        chk_lk("mp.ch1", 1, 4'b0001);
        chk_lk("mp.ch2", 2, 4'b1010);
        chk_lk("mp.ch3", 3, 4'b0110);
        lkp_valid_i = '0;
        tick();
        chk("mp.drop", 64'(lkp_valid_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pma_region_table.md
PMA_REGION_TABLE -- requirements
Module: pma_region_table

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration supplying PLEN and static Cached/Execute/NonIdempotent rules.
REQ-002 SHALL have parameter NrRegions, default 8, number of runtime-programmable regions (1..16).
REQ-003 SHALL have parameter NrLookupPorts, default 2, number of independent lookup channels (1..4).
REQ-004 SHALL have parameter LookupLatency, default 1, lookup result latency in cycles (0 or 1).
REQ-005 SHALL have port clk_i, input, 1, clock.
REQ-006 SHALL have port rst_ni, input, 1, reset; one clock, asynchronous, active-low.
REQ-007 SHALL have port cfg_req_i, input, 1, programming request.
REQ-008 SHALL have port cfg_we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port cfg_idx_i, input, $clog2(NrRegions) (minimum 1), region index.
REQ-010 SHALL have port cfg_field_i, input, 2, field select: 0 = base, 1 = length, 2 = attr, 3 = reserved.
REQ-011 SHALL have port cfg_wdata_i, input, PLEN, write data; attr uses bits [4:0] = {lock, nonidem, exec, cached, valid}.
REQ-012 SHALL have port cfg_rvalid_o, output, 1, response strobe.
REQ-013 SHALL have port cfg_rdata_o, output, PLEN, read data.
REQ-014 SHALL have port cfg_err_o, output, 1, response error.
REQ-015 SHALL have port lkp_valid_i, input, NrLookupPorts, per-channel lookup request.
REQ-016 SHALL have port lkp_addr_i, input, NrLookupPorts x PLEN, physical addresses.
REQ-017 SHALL have port lkp_valid_o, input-aligned output, NrLookupPorts, result valid.
REQ-018 SHALL have ports lkp_hit_o, lkp_cached_o, lkp_exec_o and lkp_nonidem_o, each output, NrLookupPorts, per-channel attributes.

Function
REQ-019 A region SHALL match addr when valid=1, length!=0 and base <= addr < base+length, with the sum computed at PLEN+1 bits so that no wrap-around occurs.
REQ-020 When several regions match, the lowest index SHALL win; lkp_hit_o=1 and the attributes SHALL be taken from that region.
REQ-021 On no match, lkp_hit_o SHALL be 0 and the attributes SHALL come from the static CVA6Cfg rules, where length 0 or rule count 0 means no match.
REQ-022 When LookupLatency=1, the outputs SHALL be registered and appear exactly one cycle after lkp_valid_i; when LookupLatency=0, they SHALL be combinational.
REQ-023 Each channel SHALL be independent; all channels SHALL be serviced every cycle, with no back-pressure.
REQ-024 Every cfg_req_i SHALL be accepted immediately; cfg_rvalid_o SHALL pulse exactly one cycle later.
REQ-025 On a read, cfg_rdata_o SHALL return the field zero-extended; on a write, cfg_rdata_o SHALL be 0.
REQ-026 cfg_err_o SHALL be 1 for: cfg_idx_i >= NrRegions, field 3, or a write to a locked region; an erroring write SHALL change no state.
REQ-027 Once lock=1, the region SHALL be immutable until reset; a write to attr with lock=1 SHALL take effect, and the lock SHALL apply from the next cycle.
REQ-028 A lookup in the same cycle as a write SHALL use the pre-write table; the first lookup to see the new value is the one issued on the following cycle.
REQ-029 The 0 -> 1 transition of valid SHALL be the only path that enables a region; base and length SHALL be writable while valid=1 unless locked.

Reset
REQ-030 While rst_ni=0, all table entries (base, length, attr including lock) SHALL be 0.
REQ-031 While rst_ni=0, cfg_rvalid_o, cfg_err_o, cfg_rdata_o and all lkp_*_o registered outputs SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abort any pending response, and no cfg_rvalid_o SHALL follow the deassertion.

Structure
REQ-033 The attr bit-field struct, the field encoding and the NrRegions maximum SHALL live in a shared package, pma_pkg.
REQ-034 A single sub-module, pma_region_match, SHALL be instantiated once per lookup channel: combinational priority match of one address against the table plus the static fallback.

Verification
REQ-035 Programming scenario: program region 0 with base 0x8000_0000, len 0x1000, attr 0x03; lookup at 0x8000_0FFF -> hit=1, cached=1, exec=0 after 1 cycle; lookup at 0x8000_1000 -> hit=0 with the static attributes.
REQ-036 Overlap scenario: region 1 = 0x0..0x2000 non-idempotent and region 3 = 0x1000..0x3000 cached; lookup at 0x1800 -> region 1 attributes (nonidem=1, cached=0).
REQ-037 Lock scenario: write attr 0x11 to region 2, then write base -> cfg_err_o=1 and the base is unchanged; after a rst_ni pulse, the write succeeds.
REQ-038 Simultaneous-event scenario: in the same cycle, write valid=1 to region 0 and look up inside it -> hit=0; the same lookup on the next cycle -> hit=1.
REQ-039 Boundary scenario: base = 2^PLEN - 0x10, len 0x20 -> address 2^PLEN-1 hits with no wrap; address 0 misses; idx = NrRegions -> cfg_err_o=1.
REQ-040 Multi-port scenario: with NrLookupPorts=4, issue 4 different addresses in the same cycle -> 4 independent correct results, and lkp_valid_o mirrors lkp_valid_i delayed by 1 cycle.
